// File: rtl/mcu_gpio_pkg.sv
// Shared types and constants for the MCU GPIO receive bridge.
package mcu_gpio_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

  // Number of bits needed to hold values 0..v-1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcu_gpio_rx_bridge_if.sv
// Received-word valid/ready port; optional rx_parity_err under MCU_GPIO_RX_PARITY_EN.
interface mcu_gpio_rx_bridge_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overflow;
  logic              rx_timeout;
`ifdef MCU_GPIO_RX_PARITY_EN
  logic              rx_parity_err;

  modport master (output rx_data, rx_valid, rx_overflow, rx_timeout, rx_parity_err,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, rx_overflow, rx_timeout, rx_parity_err,
                  output rx_ready);
`else
  modport master (output rx_data, rx_valid, rx_overflow, rx_timeout,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, rx_overflow, rx_timeout,
                  output rx_ready);
`endif

endinterface

// File: rtl/mcu_gpio_sync.sv
// Pin mask, synchroniser and registered rising-edge detect for one MCU GPIO pin.
module mcu_gpio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic out_i,
  input  logic oe_n_i,
  output logic level_o,
  output logic rise_o
);

  logic                   pin_c;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   rise_q;

  // An undriven pin reads as 0
  assign pin_c = out_i & ~oe_n_i;

  // Synchroniser chain; level and rise pulse are aligned one stage past the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_c};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/mcu_gpio_rx_bridge.sv
// Bit-banged 2-wire receiver: gpio_h1 strobe, gpio_h0 data, MSB-first words.
// Optional even-parity bit per word when MCU_GPIO_RX_PARITY_EN is defined.
module mcu_gpio_rx_bridge
  import mcu_gpio_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gpio_h0_out_i,
  input  logic                 gpio_h0_oe_n_i,
  input  logic                 gpio_h1_out_i,
  input  logic                 gpio_h1_oe_n_i,
  output logic                 gpio_h0_in_o,
  output logic                 gpio_h1_in_o,
  mcu_gpio_rx_bridge_if.master rx_if
);

  localparam int unsigned CNT_W = clog2(DATA_W);
  localparam int unsigned TMR_W = clog2(TIMEOUT);

  logic strb_rise, strb_lvl, data_rise, data_lvl;
  logic sync_unused;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;
`ifdef MCU_GPIO_RX_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic              hs_c;
  logic              done_c;
  logic [DATA_W-1:0] word_c;
  logic [DATA_W-1:0] shift_nxt_c;

  mcu_gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strb (
    .clk    (clk),
    .rst_n  (rst_n),
    .out_i  (gpio_h1_out_i),
    .oe_n_i (gpio_h1_oe_n_i),
    .level_o(strb_lvl),
    .rise_o (strb_rise)
  );

  mcu_gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk    (clk),
    .rst_n  (rst_n),
    .out_i  (gpio_h0_out_i),
    .oe_n_i (gpio_h0_oe_n_i),
    .level_o(data_lvl),
    .rise_o (data_rise)
  );

  assign sync_unused = strb_lvl ^ data_rise;
  assign shift_nxt_c = {shift_q[DATA_W-2:0], data_lvl};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef MCU_GPIO_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
`ifdef MCU_GPIO_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next state: strobe edge beats timeout; completion loads or overflows the holding register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;
`ifdef MCU_GPIO_RX_PARITY_EN
    perr_d  = 1'b0;
`endif
    done_c  = 1'b0;
    word_c  = shift_nxt_c;
    hs_c    = valid_q & rx_if.rx_ready;

    if (hs_c) begin
      valid_d = 1'b0;
      ack_d   = ~ack_q;
    end

    if (state_q != ST_IDLE && tmr_q != '1) tmr_d = tmr_q + TMR_W'(1);

    if (strb_rise) begin
      tmr_d = '0;
      case (state_q)
        ST_IDLE: begin
          shift_d = DATA_W'(data_lvl);
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_d = shift_nxt_c;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef MCU_GPIO_RX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
            done_c  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef MCU_GPIO_RX_PARITY_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          shift_d = '0;
          word_c  = shift_q;
          if (^{shift_q, data_lvl}) perr_d = 1'b1;
          else                      done_c = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmr_q == TMR_W'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      tmr_d   = '0;
      tmo_d   = 1'b1;
    end

    if (done_c) begin
      if (!valid_q || hs_c) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign gpio_h0_in_o      = valid_q;
  assign gpio_h1_in_o      = ack_q;
  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.rx_overflow = ovf_q;
  assign rx_if.rx_timeout  = tmo_q;
`ifdef MCU_GPIO_RX_PARITY_EN
  assign rx_if.rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_mcu_gpio_rx_bridge.sv
// Directed bench for mcu_gpio_rx_bridge; parity cases run when MCU_GPIO_RX_PARITY_EN is defined.
module tb_mcu_gpio_rx_bridge;

  localparam int unsigned TO = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h0_out = 1'b0, h0_oe_n = 1'b0, h1_out = 1'b0, h1_oe_n = 1'b0;
  logic h0_in, h1_in;

  mcu_gpio_rx_bridge_if #(.DATA_W(8)) rx_if ();

  mcu_gpio_rx_bridge #(.DATA_W(8), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gpio_h0_out_i (h0_out),
    .gpio_h0_oe_n_i(h0_oe_n),
    .gpio_h1_out_i (h1_out),
    .gpio_h1_oe_n_i(h1_oe_n),
    .gpio_h0_in_o  (h0_in),
    .gpio_h1_in_o  (h1_in),
    .rx_if         (rx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt = 0, vcyc_cnt = 0, ovf_cnt = 0, tmo_cnt = 0, perr_cnt = 0;
  logic [7:0] last_hs = 8'h00;

  // Event counters observed mid-cycle
  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) begin
      hs_cnt  = hs_cnt + 1;
      last_hs = rx_if.rx_data;
    end
    if (rx_if.rx_valid)    vcyc_cnt = vcyc_cnt + 1;
    if (rx_if.rx_overflow) ovf_cnt  = ovf_cnt + 1;
    if (rx_if.rx_timeout)  tmo_cnt  = tmo_cnt + 1;
`ifdef MCU_GPIO_RX_PARITY_EN
    if (rx_if.rx_parity_err) perr_cnt = perr_cnt + 1;
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    h0_out = b;
    tick(3);
    h1_out = 1'b1;
    tick(4);
    h1_out = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  function automatic logic last_bit(input logic [7:0] w);
`ifdef MCU_GPIO_RX_PARITY_EN
    return ^w;
`else
    return w[0];
`endif
  endfunction

  // Every bit of a word except the final one (parity bit when enabled)
  task automatic send_head(input logic [7:0] w);
`ifdef MCU_GPIO_RX_PARITY_EN
    send_bits(32'(w), 8);
`else
    send_bits(32'(w >> 1), 7);
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    send_head(w);
    send_bit(last_bit(w));
  endtask

  typedef struct {
    logic [7:0] word;
    logic       oe_n;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[6];
  int hs0, vc0, ov0, to0, pe0;
  logic exp_ack;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b0};
    rx_if.rx_ready = 1'b0;
    exp_ack = 1'b0;

    #23;
    check("rst_valid", 32'(rx_if.rx_valid), 0);
    check("rst_data", 32'(rx_if.rx_data), 0);
    check("rst_busy", 32'(h0_in), 0);
    check("rst_ack", 32'(h1_in), 0);
    check("rst_ovf_tmo", 32'({rx_if.rx_overflow, rx_if.rx_timeout}), 0);
    rst_n = 1'b1;
    tick(2);

    // Table: words consumed immediately with rx_ready high
    rx_if.rx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hs0 = hs_cnt; vc0 = vcyc_cnt;
      h0_oe_n = vecs[k].oe_n;
      send_word(vecs[k].word);
      tick(3);
      h0_oe_n = 1'b0;
      check("vec_hs", 32'(hs_cnt - hs0), 1);
      check("vec_data", 32'(last_hs), 32'(vecs[k].exp_data));
      check("vec_ack", 32'(h1_in), 32'(vecs[k].exp_ack));
      check("vec_vcyc", 32'(vcyc_cnt - vc0), 1);
      check("vec_valid_low", 32'(rx_if.rx_valid), 0);
    end
    exp_ack = 1'b0;

    // Overflow: 0x3C held, 0x81 dropped
    rx_if.rx_ready = 1'b0;
    ov0 = ovf_cnt;
    send_word(8'h3C);
    tick(2);
    check("ovf_first_valid", 32'(rx_if.rx_valid), 1);
    check("ovf_first_data", 32'(rx_if.rx_data), 32'h3C);
    check("ovf_busy_a", 32'(h0_in), 1);
    send_word(8'h81);
    tick(2);
    check("ovf_pulse", 32'(ovf_cnt - ov0), 1);
    check("ovf_data_kept", 32'(rx_if.rx_data), 32'h3C);
    check("ovf_busy_b", 32'(h0_in), 1);
    hs0 = hs_cnt;
    rx_if.rx_ready = 1'b1;
    tick(1);
    rx_if.rx_ready = 1'b0;
    tick(1);
    exp_ack = ~exp_ack;
    check("ovf_consume", 32'(last_hs), 32'h3C);
    check("ovf_consume_hs", 32'(hs_cnt - hs0), 1);
    check("ovf_ack", 32'(h1_in), 32'(exp_ack));
    check("ovf_busy_clear", 32'(h0_in), 0);

    // Pin edge to rx_valid latency
    rx_if.rx_ready = 1'b1;
    send_head(8'hC3);
    h0_out = last_bit(8'hC3);
    tick(3);
    h1_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_not_yet", 32'(rx_if.rx_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", 32'(rx_if.rx_valid), 1);
    check("lat_data", 32'(rx_if.rx_data), 32'hC3);
    tick(3);
    h1_out = 1'b0;
    tick(3);
    exp_ack = ~exp_ack;
    check("lat_ack", 32'(h1_in), 32'(exp_ack));

    // Timeout after a 3-bit partial word
    to0 = tmo_cnt;
    send_bits(32'h5, 3);
    tick(TO - 10);
    check("tmo_early", 32'(tmo_cnt - to0), 0);
    tick(20);
    check("tmo_pulse", 32'(tmo_cnt - to0), 1);
    check("tmo_no_valid", 32'(rx_if.rx_valid), 0);
    hs0 = hs_cnt;
    send_word(8'h55);
    tick(3);
    exp_ack = ~exp_ack;
    check("tmo_next_hs", 32'(hs_cnt - hs0), 1);
    check("tmo_next_data", 32'(last_hs), 32'h55);
    check("tmo_next_ack", 32'(h1_in), 32'(exp_ack));

    // Handshake in the exact completion cycle while 0xFF is held
    rx_if.rx_ready = 1'b0;
    ov0 = ovf_cnt;
    send_word(8'hFF);
    tick(2);
    check("cc_hold", 32'(rx_if.rx_data), 32'hFF);
    hs0 = hs_cnt;
    send_head(8'h12);
    h0_out = last_bit(8'h12);
    tick(3);
    h1_out = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_if.rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b0;
    tick(2);
    h1_out = 1'b0;
    tick(3);
    exp_ack = ~exp_ack;
    check("cc_consumed", 32'(last_hs), 32'hFF);
    check("cc_hs", 32'(hs_cnt - hs0), 1);
    check("cc_no_ovf", 32'(ovf_cnt - ov0), 0);
    check("cc_valid", 32'(rx_if.rx_valid), 1);
    check("cc_data", 32'(rx_if.rx_data), 32'h12);
    check("cc_ack", 32'(h1_in), 32'(exp_ack));
    rx_if.rx_ready = 1'b1;
    tick(1);
    exp_ack = ~exp_ack;
    check("cc_drain", 32'(last_hs), 32'h12);

    // Strobe not driven: toggling out value must produce nothing
    hs0 = hs_cnt; vc0 = vcyc_cnt; to0 = tmo_cnt;
    h1_oe_n = 1'b1;
    send_word(8'hFF);
    tick(TO + 10);
    h1_oe_n = 1'b0;
    tick(2);
    check("mask_hs", 32'(hs_cnt - hs0), 0);
    check("mask_vcyc", 32'(vcyc_cnt - vc0), 0);
    check("mask_tmo", 32'(tmo_cnt - to0), 0);

`ifdef MCU_GPIO_RX_PARITY_EN
    // Parity: 0xF0 with even parity 0 good; 0xF1 with parity 0 bad
    hs0 = hs_cnt; pe0 = perr_cnt;
    send_bits(32'hF0, 8);
    send_bit(1'b0);
    tick(3);
    exp_ack = ~exp_ack;
    check("par_good_hs", 32'(hs_cnt - hs0), 1);
    check("par_good_data", 32'(last_hs), 32'hF0);
    check("par_good_noerr", 32'(perr_cnt - pe0), 0);
    hs0 = hs_cnt; vc0 = vcyc_cnt;
    send_bits(32'hF1, 8);
    send_bit(1'b0);
    tick(3);
    check("par_bad_err", 32'(perr_cnt - pe0), 1);
    check("par_bad_hs", 32'(hs_cnt - hs0), 0);
    check("par_bad_vcyc", 32'(vcyc_cnt - vc0), 0);
`endif

    // Async reset mid-word drops the partial word and clears ack
    if (exp_ack == 1'b0) begin
      send_word(8'h11);
      tick(3);
      exp_ack = ~exp_ack;
    end
    check("pre_rst_ack", 32'(h1_in), 1);
    send_bits(32'h9, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(h1_in), 0);
    check("arst_valid", 32'(rx_if.rx_valid), 0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(2);
    hs0 = hs_cnt;
    send_word(8'h96);
    tick(3);
    check("post_rst_hs", 32'(hs_cnt - hs0), 1);
    check("post_rst_data", 32'(last_hs), 32'h96);
    check("post_rst_ack", 32'(h1_in), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
